// File: rtl/multi_timer_pkg.sv
// Shared types and default sizing for the multi-channel timer.
// Channel state encoding is shared by the top and the per-channel FSM.
package multi_timer_pkg;

    typedef enum logic {CH_IDLE, CH_RUN} chan_state_e;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_PRE_W = 8;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: run/idle FSM, down-counter, one-cycle done pulse and sticky expired flag.
// Advances only on the shared prescaler tick; stop beats start, and start beats tick.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_periodic,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_clr_expired,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_expired,
    output logic [WIDTH-1:0] o_count
);

    chan_state_e      r_state;
    chan_state_e      w_nxt_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_nxt_count;
    logic             r_done;
    logic             r_expired;
    logic             w_expire;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_count = r_count;
        w_expire    = 1'b0;
        if (i_stop) begin
            w_nxt_state = CH_IDLE;
            w_nxt_count = '0;
        end else if (i_start) begin
            // restart while running discards any tick in the same cycle
            w_nxt_state = CH_RUN;
            w_nxt_count = i_load_val;
        end else if (r_state == CH_RUN && i_tick) begin
            if (r_count != '0) begin
                w_nxt_count = r_count - WIDTH'(1);
            end else begin
                w_expire = 1'b1;
                if (i_periodic) begin
                    w_nxt_count = i_load_val;
                end else begin
                    w_nxt_state = CH_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CH_IDLE;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_count <= w_nxt_count;
            r_done  <= w_expire;
            // a new expiry wins over a coincident clear
            if (w_expire) begin
                r_expired <= 1'b1;
            end else if (i_clr_expired) begin
                r_expired <= 1'b0;
            end
        end
    end

    assign o_busy    = (r_state == CH_RUN);
    assign o_done    = r_done;
    assign o_expired = r_expired;
    assign o_count   = r_count;

endmodule

// File: rtl/multi_timer.sv
// N-channel programmable down-counting timer sharing one free-running prescaler.
// Each channel is an independent timer_channel instance driven by the common tick.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRE_W-1:0]      i_prescale,
    input  logic [N_CH-1:0]       i_start,
    input  logic [N_CH-1:0]       i_stop,
    input  logic [N_CH-1:0]       i_periodic,
    input  logic [N_CH*WIDTH-1:0] i_load_val,
    input  logic [N_CH-1:0]       i_clr_expired,
    output logic [N_CH-1:0]       o_busy,
    output logic [N_CH-1:0]       o_done,
    output logic [N_CH-1:0]       o_expired,
    output logic [N_CH*WIDTH-1:0] o_count
);

    logic [PRE_W-1:0] r_pre_cnt;
    logic             w_tick;

    // >= rather than == so lowering prescale ticks at once instead of wrapping
    assign w_tick = (r_pre_cnt >= i_prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk           (clk),
            .rst           (rst),
            .i_tick        (w_tick),
            .i_start       (i_start[g]),
            .i_stop        (i_stop[g]),
            .i_periodic    (i_periodic[g]),
            .i_load_val    (i_load_val[g*WIDTH +: WIDTH]),
            .i_clr_expired (i_clr_expired[g]),
            .o_busy        (o_busy[g]),
            .o_done        (o_done[g]),
            .o_expired     (o_expired[g]),
            .o_count       (o_count[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer: one task per scenario, hand-computed expectations.
module tb_multi_timer;

    localparam int N_CH  = 4;
    localparam int WIDTH = 16;
    localparam int PRE_W = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [PRE_W-1:0]      prescale = '0;
    logic [N_CH-1:0]       start = '0;
    logic [N_CH-1:0]       stop = '0;
    logic [N_CH-1:0]       periodic = '0;
    logic [N_CH*WIDTH-1:0] load_val = '0;
    logic [N_CH-1:0]       clr_expired = '0;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       done;
    logic [N_CH-1:0]       expired;
    logic [N_CH*WIDTH-1:0] count;

    int n_pass = 0;
    int n_total = 0;

    multi_timer #(.N_CH(N_CH), .WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_prescale    (prescale),
        .i_start       (start),
        .i_stop        (stop),
        .i_periodic    (periodic),
        .i_load_val    (load_val),
        .i_clr_expired (clr_expired),
        .o_busy        (busy),
        .o_done        (done),
        .o_expired     (expired),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] cnt(input int ch);
        return count[ch*WIDTH +: WIDTH];
    endfunction

    // leaves the prescaler at pre_cnt=0 right after a posedge
    task automatic do_reset();
        start = '0; stop = '0; periodic = '0; load_val = '0; clr_expired = '0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_total++;
        if ({busy, done, expired} !== '0 || count !== '0) begin
            $display("FAIL reset: busy=%b done=%b expired=%b count=%h, required all 0",
                     busy, done, expired, count);
        end else n_pass++;
        do_reset();
    endtask

    task automatic test_oneshot();
        do_reset();
        prescale = 8'd0;
        load_val[0*WIDTH +: WIDTH] = 16'd4;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n_total++;
        if (cnt(0) !== 16'd4 || busy[0] !== 1'b1) begin
            $display("FAIL oneshot_load: count=%0d busy=%b, required 4/1", cnt(0), busy[0]);
        end else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_total++;
            if (cnt(0) !== 16'(4 - k) || done[0] !== 1'b0) begin
                $display("FAIL oneshot_dec%0d: count=%0d done=%b, required %0d/0",
                         k, cnt(0), done[0], 4 - k);
            end else n_pass++;
        end
        step();
        n_total++;
        if (done[0] !== 1'b1 || busy[0] !== 1'b0 || expired[0] !== 1'b1 || cnt(0) !== 16'd0) begin
            $display("FAIL oneshot_expire: done=%b busy=%b expired=%b count=%0d, required 1/0/1/0",
                     done[0], busy[0], expired[0], cnt(0));
        end else n_pass++;
        step();
        n_total++;
        if (done[0] !== 1'b0 || expired[0] !== 1'b1 || busy[0] !== 1'b0) begin
            $display("FAIL oneshot_after: done=%b expired=%b busy=%b, required 0/1/0",
                     done[0], expired[0], busy[0]);
        end else n_pass++;
        clr_expired[0] = 1'b1;
        step();
        clr_expired[0] = 1'b0;
        n_total++;
        if (expired[0] !== 1'b0) begin
            $display("FAIL oneshot_clr: expired=%b, required 0", expired[0]);
        end else n_pass++;
    endtask

    task automatic test_periodic();
        int done_at[$];
        logic [WIDTH-1:0] seq[$];
        logic [WIDTH-1:0] exp_seq[7] = '{16'd2, 16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2};
        do_reset();
        prescale = 8'd3;
        load_val[1*WIDTH +: WIDTH] = 16'd2;
        periodic[1] = 1'b1;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        seq.push_back(cnt(1));
        for (int c = 1; c <= 200 && done_at.size() < 5; c++) begin
            step();
            if (done[1]) done_at.push_back(c);
            if (seq.size() < 7 && cnt(1) !== seq[$]) seq.push_back(cnt(1));
        end
        n_total++;
        if (done_at.size() != 5) begin
            $display("FAIL periodic_count: saw %0d done pulses, required 5", done_at.size());
        end else begin
            n_pass++;
            for (int i = 1; i < 5; i++) begin
                n_total++;
                if (done_at[i] - done_at[i-1] != 12) begin
                    $display("FAIL periodic_interval%0d: %0d cycles, required 12",
                             i, done_at[i] - done_at[i-1]);
                end else n_pass++;
            end
        end
        for (int i = 0; i < 7; i++) begin
            n_total++;
            if (i >= seq.size() || seq[i] !== exp_seq[i]) begin
                $display("FAIL periodic_seq%0d: got %0d, required %0d",
                         i, (i < seq.size()) ? seq[i] : 16'hFFFF, exp_seq[i]);
            end else n_pass++;
        end
        n_total++;
        if (busy[1] !== 1'b1) begin
            $display("FAIL periodic_busy: busy=%b, required 1", busy[1]);
        end else n_pass++;
    endtask

    task automatic test_stop_start();
        int guard = 0;
        int n_done = 0;
        do_reset();
        prescale = 8'd0;
        load_val[2*WIDTH +: WIDTH] = 16'd20;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        while (cnt(2) !== 16'd7 && guard < 40) begin
            step();
            guard++;
        end
        n_total++;
        if (cnt(2) !== 16'd7 || guard != 13) begin
            $display("FAIL stop_reach7: count=%0d after %0d cycles, required 7 after 13",
                     cnt(2), guard);
        end else n_pass++;
        stop[2] = 1'b1;
        start[2] = 1'b1;
        step();
        stop[2] = 1'b0;
        start[2] = 1'b0;
        n_total++;
        if (cnt(2) !== 16'd0 || busy[2] !== 1'b0 || done[2] !== 1'b0) begin
            $display("FAIL stop_win: count=%0d busy=%b done=%b, required 0/0/0",
                     cnt(2), busy[2], done[2]);
        end else n_pass++;
        for (int c = 0; c < 25; c++) begin
            step();
            if (done[2] || cnt(2) != 0) n_done++;
        end
        n_total++;
        if (n_done != 0 || expired[2] !== 1'b0) begin
            $display("FAIL stop_quiet: %0d active cycles expired=%b, required 0/0",
                     n_done, expired[2]);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        prescale = 8'd0;
        load_val[0*WIDTH +: WIDTH] = 16'd0;
        periodic[0] = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n_total++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b1 || cnt(0) !== 16'd0) begin
            $display("FAIL b2b_start: done=%b busy=%b count=%0d, required 0/1/0",
                     done[0], busy[0], cnt(0));
        end else n_pass++;
        for (int c = 1; c <= 5; c++) begin
            step();
            n_total++;
            if (done[0] !== 1'b1 || busy[0] !== 1'b1) begin
                $display("FAIL b2b_done%0d: done=%b busy=%b, required 1/1", c, done[0], busy[0]);
            end else n_pass++;
        end
        clr_expired[0] = 1'b1;
        step();
        clr_expired[0] = 1'b0;
        n_total++;
        if (expired[0] !== 1'b1 || done[0] !== 1'b1) begin
            $display("FAIL b2b_clr_vs_set: expired=%b done=%b, required 1/1", expired[0], done[0]);
        end else n_pass++;
    endtask

    task automatic test_all_channels();
        int first[N_CH];
        int ndone[N_CH];
        int exp_first[N_CH] = '{3, 7, 11, 15};
        do_reset();
        prescale = 8'd1;
        load_val = {16'd7, 16'd5, 16'd3, 16'd1};
        start = '1;
        for (int i = 0; i < N_CH; i++) begin
            first[i] = -1;
            ndone[i] = 0;
        end
        step();
        start = '0;
        for (int c = 1; c <= 25; c++) begin
            step();
            for (int i = 0; i < N_CH; i++) begin
                if (done[i]) begin
                    ndone[i]++;
                    if (first[i] < 0) first[i] = c;
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            n_total++;
            if (first[i] != exp_first[i] || ndone[i] != 1) begin
                $display("FAIL allch%0d: done at %0d (x%0d), required at %0d (x1)",
                         i, first[i], ndone[i], exp_first[i]);
            end else n_pass++;
        end
        n_total++;
        if (busy !== '0 || expired !== '1) begin
            $display("FAIL allch_final: busy=%b expired=%b, required 0000/1111", busy, expired);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        prescale = 8'd0;
        load_val[0*WIDTH +: WIDTH] = 16'd10;
        load_val[3*WIDTH +: WIDTH] = 16'd0;
        periodic[3] = 1'b1;
        start[0] = 1'b1;
        start[3] = 1'b1;
        step();
        start = '0;
        step(); step(); step();
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (busy !== '0 || done !== '0 || expired !== '0 || count !== '0) begin
            $display("FAIL async_rst: busy=%b done=%b expired=%b count=%h, required all 0",
                     busy, done, expired, count);
        end else n_pass++;
        step();
        rst = 1'b0;
        step(); step(); step();
        n_total++;
        if (busy !== '0 || done !== '0 || expired !== '0 || count !== '0) begin
            $display("FAIL rst_release: busy=%b done=%b expired=%b count=%h, required all 0",
                     busy, done, expired, count);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop_start();
        test_back_to_back();
        test_all_channels();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
